// File: rtl/button_bit_encoder.sv
// Two bouncing push-buttons to single-cycle bit events (A enters 1, B enters 0).
// Latency: pulse on bit_valid DEBOUNCE_CYCLES+2 edges after the first edge that samples a stable new level.
// No back-pressure: one event per press/release; presses while another button is held are dropped.
module button_bit_encoder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_a,
  input  logic btn_b,
  output logic bit_valid,
  output logic bit_value,
  output logic conflict,
  output logic busy
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HELD = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Per-button vectors: bit 1 is button A, bit 0 is button B.
  logic [1:0]       s1_q, s1_d;
  logic [1:0]       s2_q, s2_d;
  logic [1:0]       deb_q, deb_d;
  logic [1:0]       deb_dly_q, deb_dly_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [1:0]       rise;

  logic [0:0] state_q, state_d;
  logic       bit_valid_q, bit_valid_d;
  logic       bit_value_q, bit_value_d;
  logic       conflict_q, conflict_d;
  logic       busy_q, busy_d;

  // Two-flop synchronizer and one-cycle delayed debounced level for edge detect.
  always_comb begin
    s1_d      = {btn_a, btn_b};
    s2_d      = s1_q;
    deb_dly_d = deb_q;
  end

  // Debounce: the synchronized level must differ from deb for DEBOUNCE_CYCLES
  // consecutive cycles; any cycle where it matches deb restarts the count.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        deb_d[i] = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  assign rise = deb_q & ~deb_dly_q;

  // Press FSM: only a rise seen from IDLE produces an event; HELD waits for
  // both debounced levels low, so the release is also fully debounced.
  always_comb begin
    state_d     = state_q;
    bit_valid_d = 1'b0;
    conflict_d  = 1'b0;
    bit_value_d = bit_value_q;
    case (state_q)
      ST_IDLE: begin
        case (rise)
          2'b10: begin
            bit_valid_d = 1'b1;
            bit_value_d = 1'b1;
            state_d     = ST_HELD;
          end
          2'b01: begin
            bit_valid_d = 1'b1;
            bit_value_d = 1'b0;
            state_d     = ST_HELD;
          end
          2'b11: begin
            conflict_d = 1'b1;
            state_d    = ST_HELD;
          end
          default: state_d = ST_IDLE;
        endcase
      end
      ST_HELD: begin
        if (deb_q == 2'b00) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // All state, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= '0;
      s2_q        <= '0;
      deb_q       <= '0;
      deb_dly_q   <= '0;
      cnt_q[0]    <= '0;
      cnt_q[1]    <= '0;
      state_q     <= ST_IDLE;
      bit_valid_q <= 1'b0;
      bit_value_q <= 1'b0;
      conflict_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      deb_q       <= deb_d;
      deb_dly_q   <= deb_dly_d;
      cnt_q[0]    <= cnt_d[0];
      cnt_q[1]    <= cnt_d[1];
      state_q     <= state_d;
      bit_valid_q <= bit_valid_d;
      bit_value_q <= bit_value_d;
      conflict_q  <= conflict_d;
      busy_q      <= busy_d;
    end
  end

  assign bit_valid = bit_valid_q;
  assign bit_value = bit_value_q;
  assign conflict  = conflict_q;
  assign busy      = busy_q;

endmodule
